// File: rtl/text_console.sv
// Byte-stream terminal front end for the 40x30 character RAM: cursor, scroll and clear.
// Optional TAB handling is enabled by defining CONSOLE_TAB_EN.
module text_console #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter int         TOTAL      = COLS * ROWS,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wr,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [10:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [10:0] LAST_ADDR     = 11'(TOTAL - 1);
    localparam logic [10:0] COLS_A        = 11'(COLS);
    localparam logic [10:0] LAST_COPY     = 11'(TOTAL - COLS - 1);
    localparam logic [10:0] LAST_ROW_BASE = 11'(TOTAL - COLS);
    localparam logic [5:0]  LAST_COL      = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        CLEAR_ALL,
        IDLE,
        PUT,
        SCROLL,
        CLEAR_ROW
    } state_t;

    state_t      state;
    logic [7:0]  data_q;
    logic [10:0] line_base;

    logic        printable_in;
    logic        printable_q;
    logic [10:0] cell_addr;
    logic [5:0]  put_col;
    logic        put_adv;
    logic        put_ff;
`ifdef CONSOLE_TAB_EN
    logic [5:0]  tab_col;
`endif

    always_comb begin
        printable_in = (in_data >= 8'h20) && (in_data <= 8'h7E);
        printable_q  = (data_q >= 8'h20) && (data_q <= 8'h7E);
        cell_addr    = line_base + {5'd0, cursor_col};
        put_col      = cursor_col;
        put_adv      = 1'b0;
        put_ff       = 1'b0;
`ifdef CONSOLE_TAB_EN
        tab_col      = (cursor_col | 6'd7) + 6'd1;
`endif
        case (data_q)
            8'h0D: put_col = '0;
            8'h0A: begin
                put_col = '0;
                put_adv = 1'b1;
            end
            8'h08: begin
                if (cursor_col != '0) put_col = cursor_col - 6'd1;
            end
            8'h0C: put_ff = 1'b1;
`ifdef CONSOLE_TAB_EN
            8'h09: begin
                if (tab_col >= 6'(COLS)) begin
                    put_col = '0;
                    put_adv = 1'b1;
                end else begin
                    put_col = tab_col;
                end
            end
`endif
            default: begin
                if (printable_q) begin
                    if (cursor_col == LAST_COL) begin
                        put_col = '0;
                        put_adv = 1'b1;
                    end else begin
                        put_col = cursor_col + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLEAR_ALL;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd_addr <= '0;
            cursor_col  <= '0;
            cursor_row  <= '0;
            line_base   <= '0;
            data_q      <= '0;
        end else begin
            case (state)
                CLEAR_ALL: begin
                    if (!mem_wr) begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= BLANK_CHAR;
                    end else if (mem_addr == LAST_ADDR) begin
                        mem_wr      <= 1'b0;
                        cursor_col  <= '0;
                        cursor_row  <= '0;
                        line_base   <= '0;
                        mem_rd_addr <= COLS_A;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        mem_addr <= mem_addr + 11'd1;
                    end
                end

                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= PUT;
                        // The PUT-cycle write is registered here so it is visible during PUT.
                        if (printable_in) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= cell_addr;
                            mem_wdata <= in_data;
                        end else if (in_data == 8'h08 && cursor_col != '0) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= cell_addr - 11'd1;
                            mem_wdata <= BLANK_CHAR;
                        end
                    end
                end

                PUT: begin
                    mem_wr     <= 1'b0;
                    cursor_col <= put_col;
                    if (put_ff) begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        line_base  <= '0;
                        busy       <= 1'b1;
                        mem_wr     <= 1'b1;
                        mem_addr   <= '0;
                        mem_wdata  <= BLANK_CHAR;
                        state      <= CLEAR_ALL;
                    end else if (put_adv && cursor_row == LAST_ROW) begin
                        // rd_addr has held COLS since IDLE, so the first source byte
                        // arrives in the first SCROLL cycle.
                        busy        <= 1'b1;
                        mem_rd_addr <= COLS_A + 11'd1;
                        state       <= SCROLL;
                    end else begin
                        if (put_adv) begin
                            cursor_row <= cursor_row + 5'd1;
                            line_base  <= line_base + COLS_A;
                        end
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end

                SCROLL: begin
                    if (mem_wr && mem_addr == LAST_COPY) begin
                        mem_addr  <= LAST_ROW_BASE;
                        mem_wdata <= BLANK_CHAR;
                        state     <= CLEAR_ROW;
                    end else begin
                        mem_wr    <= 1'b1;
                        mem_wdata <= mem_rd_data;
                        mem_addr  <= mem_wr ? mem_addr + 11'd1 : '0;
                        if (mem_rd_addr != LAST_ADDR) mem_rd_addr <= mem_rd_addr + 11'd1;
                    end
                end

                CLEAR_ROW: begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_wr      <= 1'b0;
                        mem_rd_addr <= COLS_A;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        mem_addr <= mem_addr + 11'd1;
                    end
                end

                default: state <= CLEAR_ALL;
            endcase
        end
    end

endmodule
